// File: rtl/demux1x4_buf.sv
// demux1x4_buf: one input stream is steered by sel into one of four
// independent FIFO channels. Each channel has its own valid/ready output
// handshake. All outputs are derived from registered state only.
`timescale 1ns/1ps

module demux1x4_buf #(
    parameter int DW    = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     din,
    input  logic [1:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [4*DW-1:0]   dout,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [3:0]        ch_full
);

    // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q    [4][DEPTH];
    logic [DW-1:0] mem_d    [4][DEPTH];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] count_q  [4];
    logic [CW-1:0] count_d  [4];

    logic [3:0] push;
    logic [3:0] pop;
    logic [3:0] full_int;

    // Channel status and head data, all taken from registered state; an empty channel drives zeros.
    always_comb begin
        dout     = '0;
        full_int = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (count_q[k] != '0);
            full_int[k]  = (count_q[k] == CW'(DEPTH));
            if (count_q[k] != '0) begin
                dout[k*DW +: DW] = mem_q[k][rd_ptr_q[k]];
            end
        end
        ch_full  = full_int;
        in_ready = !full_int[sel];
    end

    // Next-state: one push into the selected channel plus independent pops on any channel.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < 4; k++) begin
            mem_d[k]    = mem_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            count_d[k]  = count_q[k];

            push[k] = in_valid && !full_int[sel] && (sel == 2'(k));
            pop[k]  = (count_q[k] != '0) && out_ready[k];

            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = din;
                wr_ptr_d[k]           = wr_ptr_q[k] + AW'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   count_d[k] = count_q[k] + CW'(1);
                2'b01:   count_d[k] = count_q[k] - CW'(1);
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    // State registers; reset clears contents, pointers and occupancy and suppresses all transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[k][e] <= mem_d[k][e];
                end
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                count_q[k]  <= count_d[k];
            end
        end
    end

endmodule

// File: tb/tb_demux1x4_buf.sv
// Testbench for demux1x4_buf: per-channel queue scoreboard checked every cycle.
`timescale 1ns/1ps

module tb_demux1x4_buf;

    localparam int DW    = 4;
    localparam int DEPTH = 2;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     din;
    logic [1:0]        sel;
    logic              in_valid;
    logic              in_ready;
    logic [4*DW-1:0]   dout;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [3:0]        ch_full;

    int compared;
    int mismatched;
    logic [DW-1:0] model_q [4][$];
    logic [3:0] cov_full;
    logic [3:0] cov_sel;

    demux1x4_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ch_full   (ch_full)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, check pre-edge outputs against the model, then update the model.
    task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] s,
                                 input logic [DW-1:0] d, input logic [3:0] ordy);
        logic [4*DW-1:0] exp_dout;
        logic [3:0]      exp_valid;
        logic [3:0]      exp_full;
        logic            exp_ready;
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        sel       = s;
        din       = d;
        out_ready = ordy;
        #1;
        exp_dout  = '0;
        exp_valid = '0;
        exp_full  = '0;
        for (int k = 0; k < 4; k++) begin
            exp_valid[k] = (model_q[k].size() > 0);
            exp_full[k]  = (model_q[k].size() == DEPTH);
            if (exp_valid[k]) exp_dout[k*DW +: DW] = model_q[k][0];
        end
        exp_ready = (model_q[s].size() < DEPTH);
        checkOutput("in_ready",  32'(in_ready),  32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("ch_full",   32'(ch_full),   32'(exp_full));
        checkOutput("dout",      32'(dout),      32'(exp_dout));
        cov_full |= ch_full;
        if (r) begin
            for (int k = 0; k < 4; k++) model_q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (exp_valid[k] && ordy[k]) void'(model_q[k].pop_front());
            end
            if (iv && exp_ready) begin
                model_q[s].push_back(d);
                cov_sel[s] = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cov_full   = '0;
        cov_sel    = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        sel        = 2'd0;
        din        = '0;
        out_ready  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_dout",      32'(dout),      32'h0);
        checkOutput("rst_ch_full",   32'(ch_full),   32'h0);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        end

        // Single word to channel 2 appears the following cycle.
        applyStimulus(1'b0, 1'b1, 2'd2, 4'hA, 4'h0);
        #1;
        checkOutput("lat_out_valid", 32'(out_valid), 32'h4);
        checkOutput("lat_dout",      32'(dout),      32'h0A00);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

        // Fill channel 0, then a third push is refused.
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h1, 4'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h2, 4'h0);
        #1;
        checkOutput("full_ch0", 32'(ch_full), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h7, 4'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 4'h9, 4'h0);

        // Full channel popped and pushed together: only the pop happens.
        applyStimulus(1'b0, 1'b1, 2'd0, 4'h3, 4'h1);
        #1;
        checkOutput("popfull_head", 32'(dout[3:0]), 32'h2);
        checkOutput("popfull_full", 32'(ch_full[0]), 32'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

        // Channel 3 simultaneous push/pop for ten cycles to wrap pointers.
        applyStimulus(1'b0, 1'b1, 2'd3, 4'h4, 4'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 2'd3, 4'(5 + i), 4'h8);
        end
        #1;
        checkOutput("wrap_head", 32'(dout[15:12]), 32'hE);
        checkOutput("wrap_valid", 32'(out_valid), 32'h8);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

        // All channels full, then reset with traffic pending.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 2'(k % 4), 4'(k + 1), 4'h0);
        end
        applyStimulus(1'b1, 1'b1, 2'd1, 4'hF, 4'hF);
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_dout",  32'(dout),      32'h0);
        checkOutput("midrst_full",  32'(ch_full),   32'h0);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ordy;
            for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)), 4'($urandom), ordy);
        end
        checkOutput("cov_full", 32'(cov_full), 32'hF);
        checkOutput("cov_sel",  32'(cov_sel),  32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux1x4_buf.md
DEMUX1X4_BUF -- requirements
Module: demux1x4_buf

Interface
REQ-001 Parameter DW, default 4, SHALL be the data width of the input word and of each output channel.
REQ-002 Parameter DEPTH, default 2, SHALL be the per-channel buffer depth; legal values are 2, 4 and 8.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 din  in  DW  input data word.
REQ-007 sel  in  2  destination channel index, 0..3.
REQ-008 in_valid  in  1  din/sel valid this cycle.
REQ-009 in_ready  out  1  block can accept din into channel sel this cycle.
REQ-010 dout  out  4*DW  channel k data at bits [k*DW +: DW].
REQ-011 out_valid  out  4  bit k set: channel k head data valid.
REQ-012 out_ready  in  4  bit k set: consumer k takes head this cycle.
REQ-013 ch_full  out  4  bit k set: channel k holds DEPTH entries.

Function
REQ-014 Input transfer SHALL occur exactly when in_valid=1 and in_ready=1 on a rising clk edge; the word SHALL be written to the tail of channel sel's FIFO.
REQ-015 in_ready SHALL equal !ch_full[sel], combinational from sel and registered state only; it SHALL NOT depend on in_valid or out_ready.
REQ-016 Channel k output transfer SHALL occur exactly when out_valid[k]=1 and out_ready[k]=1 on a rising edge; the head entry is removed.
REQ-017 out_valid[k] SHALL be 1 iff channel k occupancy > 0; no combinational input-to-output bypass.
REQ-018 Latency: a word accepted at edge N SHALL appear on dout channel sel with out_valid set in the cycle after edge N, provided that channel was empty.
REQ-019 dout slice k SHALL show the head entry of channel k when out_valid[k]=1 and SHALL be all-zero when out_valid[k]=0.
REQ-020 Each channel SHALL preserve FIFO order; read and write pointers SHALL wrap modulo DEPTH.
REQ-021 Occupancy per channel SHALL be 0..DEPTH; push only: +1; pop only: -1; push and pop on the same channel in the same cycle: unchanged.
REQ-022 A full channel SHALL refuse input (in_ready=0) even when it is popped in the same cycle; the freed slot becomes available the following cycle.
REQ-023 Pops on any set of channels and a push to any channel SHALL all be able to occur in the same cycle without interaction between channels.
REQ-024 in_valid=1 with in_ready=0 SHALL leave all state unchanged, and the word SHALL NOT be stored.
REQ-025 ch_full[k] SHALL be registered-state derived: 1 iff occupancy of channel k equals DEPTH.

Reset
REQ-026 While rst=1 at an edge, all occupancies and pointers SHALL become 0 and buffer contents SHALL be cleared to 0.
REQ-027 After reset: out_valid=4'b0000, dout=0, ch_full=4'b0000, in_ready=1 for any sel.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words; no transfer SHALL occur at an edge where rst=1, regardless of in_valid or out_ready.

Verification
REQ-029 Reset, then in_valid=1, din=4'hA, sel=2 for one cycle, out_ready=0 -> next cycle out_valid=4'b0100, dout[11:8]=4'hA, all other slices 0.
REQ-030 DEPTH=2, push 4'h1 then 4'h2 to channel 0, out_ready=0 -> ch_full[0]=1, in_ready=0 for sel=0 and 1 for sel=1; a third push with sel=0 is not stored.
REQ-031 Channel 0 full with out_ready[0]=1 and in_valid=1, sel=0 in the same cycle -> pop of 4'h1 only; next cycle occupancy=1, head=4'h2, in_ready=1.
REQ-032 Channel 3 holds one word; push 4'h5 to sel=3 with out_ready[3]=1 in the same cycle -> occupancy stays 1 and head becomes 4'h5; repeat for 10 cycles to exercise pointer wrap, with order preserved.
REQ-033 All four channels hold 2 words each; assert rst for one cycle with in_valid=1 and out_ready=4'hF -> next cycle out_valid=0, dout=0, ch_full=0, no word is delivered.
REQ-034 Random traffic over all sel values and out_ready patterns for 1000 cycles, checked against a per-channel queue model -> no loss, duplication or reordering, and every sel and channel full/empty transition is hit.
